// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
//   MSI snooping bus controller for CPUS data caches sharing one RAM port.
//   Round-robin arbitration of coherence transactions, one-cycle snoop
//   broadcast, block transfers of BLOCK_WORDS 32-bit words from RAM,
//   cache-to-cache forwarding with a simultaneous memory update,
//   write-backs and data-less upgrades.
//
// Ports
//   CLK, nRST                  clock (rising edge), async active-low reset
//   dREN, dWEN                 per-cache read / write-back requests
//   cctrans, ccwrite           per-cache coherence transaction / modified flag
//   daddr, dstore              per-cache address / store data (32 bits each)
//   dwait                      per-cache wait (low = word accepted)
//   ccwait, ccinv              per-cache snoop hold / invalidate
//   dload, ccsnoopaddr         per-cache load data / snoop address
//   ramREN, ramWEN             RAM read / write strobes
//   ramaddr, ramstore          RAM address / write data
//   ramload, ramstate          RAM read data / RAM status (FREE,BUSY,ACCESS,ERROR)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | scan requests from the round-robin pointer
// SNOOP | broadcast snoop address, pick the owner (lowest ccwrite)
// MEMRD | block fill from RAM
// C2C   | block forwarded from owner, written to RAM at the same time
// WB    | eviction of the requestor's block to RAM
// ACK   | upgrade acknowledge, no data phase
module coherence_bus_ctrl #(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*32-1:0]   dload,
  output logic [CPUS*32-1:0]   ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int KW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SNOOP = 3'd1;
  localparam logic [2:0] MEMRD = 3'd2;
  localparam logic [2:0] C2C   = 3'd3;
  localparam logic [2:0] WB    = 3'd4;
  localparam logic [2:0] ACK   = 3'd5;

  logic [2:0]      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   req;
  logic [PW-1:0]   owner;
  logic [KW-1:0]   k;

  logic [31:0]     r_addr;
  logic [31:0]     r_store;
  logic [31:0]     o_store;
  logic [31:0]     blk_addr;
  logic            r_active;
  logic            is_upgr;
  logic            is_inv;
  logic            word_ok;
  logic            last_word;
  logic [CPUS-1:0] others;
  logic            grant_vld;
  logic [PW-1:0]   grant_idx;
  logic            own_vld;
  logic [PW-1:0]   own_idx;
  logic [PW-1:0]   next_ptr;

  // Requestor signals are decoded live; only the index is registered.
  assign r_addr    = daddr[32*req +: 32];
  assign r_store   = dstore[32*req +: 32];
  assign o_store   = dstore[32*owner +: 32];
  assign r_active  = dREN[req] | dWEN[req] | cctrans[req];
  assign is_upgr   = cctrans[req] & ~dREN[req] & ~dWEN[req];
  assign is_inv    = is_upgr | (dREN[req] & cctrans[req] & ccwrite[req]);
  assign blk_addr  = (r_addr & ~32'(BLOCK_WORDS*4-1)) + (32'(k) << 2);
  assign word_ok   = (ramstate == RAM_ACCESS);
  assign last_word = (k == KW'(BLOCK_WORDS-1));
  assign next_ptr  = (int'(req) == CPUS-1) ? '0 : req + 1'b1;

  always_comb begin
    others      = '1;
    others[req] = 1'b0;
  end

  // Round-robin scan: a cache requests with dWEN or cctrans (dREN alone
  // is not a coherence transaction).
  always_comb begin : arb
    int c;
    grant_vld = 1'b0;
    grant_idx = '0;
    c         = 0;
    for (int i = 0; i < CPUS; i++) begin
      c = (int'(ptr) + i) % CPUS;
      if (!grant_vld && (dWEN[c] || cctrans[c])) begin
        grant_vld = 1'b1;
        grant_idx = PW'(c);
      end
    end
  end

  always_comb begin : own_search
    own_vld = 1'b0;
    own_idx = '0;
    for (int j = 0; j < CPUS; j++) begin
      if (!own_vld && (j != int'(req)) && ccwrite[j]) begin
        own_vld = 1'b1;
        own_idx = PW'(j);
      end
    end
  end

  always_comb begin : outputs
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    dload       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    if (state != IDLE) begin
      ccwait = others;
      for (int j = 0; j < CPUS; j++) begin
        if (others[j]) ccsnoopaddr[32*j +: 32] = r_addr;
      end
    end

    case (state)
      SNOOP: begin
        if (is_inv) ccinv = others;
      end
      MEMRD: begin
        ramREN               = 1'b1;
        ramaddr              = blk_addr;
        dload[32*req +: 32]  = ramload;
        if (word_ok) dwait[req] = 1'b0;
      end
      C2C: begin
        ramWEN               = 1'b1;
        ramaddr              = blk_addr;
        ramstore             = o_store;
        dload[32*req +: 32]  = o_store;
        if (word_ok) begin
          dwait[req]   = 1'b0;
          dwait[owner] = 1'b0;
        end
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = blk_addr;
        ramstore = r_store;
        if (word_ok) dwait[req] = 1'b0;
      end
      ACK: begin
        dwait[req] = 1'b0;
        ccinv      = others;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      ptr   <= '0;
      req   <= '0;
      owner <= '0;
      k     <= '0;
    end else if (state == IDLE) begin
      k <= '0;
      if (grant_vld) begin
        req   <= grant_idx;
        state <= dWEN[grant_idx] ? WB : SNOOP;
      end
    end else if (!r_active) begin
      // Requestor withdrew: abandon without advancing the pointer.
      state <= IDLE;
      k     <= '0;
    end else begin
      case (state)
        SNOOP: begin
          owner <= own_idx;
          if (is_upgr)      state <= ACK;
          else if (own_vld) state <= C2C;
          else              state <= MEMRD;
        end
        MEMRD, C2C, WB: begin
          if (word_ok) begin
            if (last_word) begin
              state <= IDLE;
              k     <= '0;
              ptr   <= next_ptr;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ACK: begin
          state <= IDLE;
          ptr   <= next_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl with CPUS=4, BLOCK_WORDS=4.
// Hand-computed transaction table, directed corner sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_coherence_bus_ctrl;
  localparam int CPUS = 4;
  localparam int BW   = 4;
  localparam int AW   = CPUS*32;

  localparam int P_MEM = 0, P_C2C = 1, P_ACK = 2, P_WB = 3;
  localparam int T_RD = 0, T_RDX = 1, T_WB = 2, T_UPGR = 3;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2;

  logic              CLK, nRST;
  logic [CPUS-1:0]   dREN, dWEN, cctrans, ccwrite;
  logic [AW-1:0]     daddr, dstore;
  logic [CPUS-1:0]   dwait, ccwait, ccinv;
  logic [AW-1:0]     dload, ccsnoopaddr;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;

  int vectors = 0;
  int miscompares = 0;

  coherence_bus_ctrl #(.CPUS(CPUS), .BLOCK_WORDS(BW)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
    .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv),
    .dload(dload), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [CPUS-1:0] ren, wen, trn, ccw;
    logic [31:0]     addr;
    int              r, path, own;
    logic [CPUS-1:0] inv;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int c, input int t, input logic [31:0] a);
    dREN[c]    = (t == T_RD) || (t == T_RDX);
    dWEN[c]    = (t == T_WB);
    cctrans[c] = (t != T_WB);
    ccwrite[c] = (t == T_RDX);
    daddr[32*c +: 32]  = a;
    dstore[32*c +: 32] = $urandom;
  endtask

  task automatic clear_req(input int c);
    dREN[c] = 1'b0; dWEN[c] = 1'b0; cctrans[c] = 1'b0; ccwrite[c] = 1'b0;
  endtask

  task automatic clear_all();
    for (int c = 0; c < CPUS; c++) clear_req(c);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_dwait"}, AW'(dwait), AW'({CPUS{1'b1}}));
    chk({tag, "_ccwait_ccinv"}, AW'({ccwait, ccinv}), '0);
    chk({tag, "_strobes"}, AW'({ramREN, ramWEN}), '0);
    chk({tag, "_ramaddr_store"}, AW'({ramaddr, ramstore}), '0);
    chk({tag, "_dload"}, dload, '0);
    chk({tag, "_snoopaddr"}, ccsnoopaddr, '0);
  endtask

  // Walks one transaction from its IDLE cycle to its last cycle.
  // ram_mode: 0 ACCESS every cycle, 1 random, 2 BUSY then ACCESS per word.
  task automatic run_txn(input int r, input int path, input int own,
                         input logic [CPUS-1:0] exp_inv, input int ram_mode);
    logic [CPUS-1:0] oth, exp_dw;
    logic [31:0]     a, base, rstore, ostore;
    logic [AW-1:0]   snp;
    int              k, tries;
    oth = '1; oth[r] = 1'b0;
    a      = daddr[32*r +: 32];
    base   = a & ~32'(BW*4-1);
    rstore = dstore[32*r +: 32];
    ostore = (own >= 0) ? dstore[32*own +: 32] : 32'h0;
    snp = '0;
    for (int j = 0; j < CPUS; j++) if (oth[j]) snp[32*j +: 32] = a;
    ramstate = R_FREE;
    @(negedge CLK);
    check_idle("txn_idle");
    tick();
    if (path != P_WB) begin
      @(negedge CLK);
      chk("snoop_ccwait", AW'(ccwait), AW'(oth));
      chk("snoop_ccinv", AW'(ccinv), AW'(exp_inv));
      chk("snoop_addr", ccsnoopaddr, snp);
      chk("snoop_dwait", AW'(dwait), AW'({CPUS{1'b1}}));
      chk("snoop_strobes", AW'({ramREN, ramWEN}), '0);
      tick();
      if (path == P_ACK) begin
        @(negedge CLK);
        chk("ack_dwait", AW'(dwait), AW'(oth));
        chk("ack_ccinv", AW'(ccinv), AW'(exp_inv));
        chk("ack_ccwait", AW'(ccwait), AW'(oth));
        chk("ack_strobes", AW'({ramREN, ramWEN}), '0);
        tick();
        return;
      end
    end
    k = 0; tries = 0;
    while (k < BW) begin
      case (ram_mode)
        0:       ramstate = R_ACCESS;
        1:       ramstate = (tries >= 4) ? R_ACCESS : 2'($urandom_range(0, 3));
        default: ramstate = (tries == 0) ? R_BUSY : R_ACCESS;
      endcase
      ramload = $urandom;
      @(negedge CLK);
      exp_dw = '1;
      if (ramstate == R_ACCESS) begin
        exp_dw[r] = 1'b0;
        if (path == P_C2C) exp_dw[own] = 1'b0;
      end
      chk("data_ramaddr", AW'(ramaddr), AW'(base + 32'(4*k)));
      chk("data_strobes", AW'({ramREN, ramWEN}), AW'((path == P_MEM) ? 2'b10 : 2'b01));
      chk("data_dwait", AW'(dwait), AW'(exp_dw));
      chk("data_ccinv", AW'(ccinv), '0);
      if (path != P_WB) chk("data_ccwait", AW'(ccwait), AW'(oth));
      if (path == P_MEM) begin
        chk("memrd_dload", AW'(dload[32*r +: 32]), AW'(ramload));
      end else if (path == P_C2C) begin
        chk("c2c_ramstore", AW'(ramstore), AW'(ostore));
        chk("c2c_dload", AW'(dload[32*r +: 32]), AW'(ostore));
      end else begin
        chk("wb_ramstore", AW'(ramstore), AW'(rstore));
      end
      tick();
      if (ramstate == R_ACCESS) begin k++; tries = 0; end
      else tries++;
    end
    ramstate = R_FREE;
  endtask

  // Reference model state for the randomized phase.
  int  m_ptr;
  bit  pend[CPUS];
  int  typ[CPUS];

  function automatic int model_grant();
    for (int i = 0; i < CPUS; i++) begin
      if (pend[(m_ptr + i) % CPUS]) return (m_ptr + i) % CPUS;
    end
    return -1;
  endfunction

  function automatic int model_owner(input int r);
    for (int j = 0; j < CPUS; j++) if (j != r && ccwrite[j]) return j;
    return -1;
  endfunction

  initial begin
    int r, own, path, t;
    logic [CPUS-1:0] inv;
    bit any;

    nRST = 1'b0; clear_all(); daddr = '0; dstore = '0;
    ramload = '0; ramstate = R_FREE;

    tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h100, 0, P_MEM, -1, 4'b0000};
    tbl[1] = '{4'b0100, 4'b0000, 4'b0100, 4'b0110, 32'h200, 2, P_C2C,  1, 4'b1011};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 32'h440, 1, P_ACK, -1, 4'b1101};
    tbl[3] = '{4'b1001, 4'b0000, 4'b1001, 4'b0000, 32'h580, 3, P_MEM, -1, 4'b0000};
    tbl[4] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h5C0, 0, P_MEM, -1, 4'b0000};
    tbl[5] = '{4'b1000, 4'b0000, 4'b1000, 4'b1011, 32'h640, 3, P_C2C,  0, 4'b0111};
    tbl[6] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 32'h2F0, 2, P_WB,  -1, 4'b0000};

    // Reset values
    #3;
    check_idle("reset");
    tick(); tick();
    nRST = 1'b1;

    // Table-driven transactions
    for (int v = 0; v < 7; v++) begin
      dREN = tbl[v].ren; dWEN = tbl[v].wen; cctrans = tbl[v].trn; ccwrite = tbl[v].ccw;
      for (int c = 0; c < CPUS; c++) begin
        daddr[32*c +: 32]  = (c == tbl[v].r) ? tbl[v].addr : 32'hA000 + 32'(c*64);
        dstore[32*c +: 32] = $urandom;
      end
      run_txn(tbl[v].r, tbl[v].path, tbl[v].own, tbl[v].inv, 0);
    end
    clear_all();

    // Write-back at 0x30C with RAM busy every other cycle (pointer at 3)
    set_req(0, T_WB, 32'h30C);
    run_txn(0, P_WB, -1, '0, 2);
    clear_all();

    // Reset during C2C word 1 (pointer at 1, only cache2 requests)
    set_req(2, T_RDX, 32'h200);
    ccwrite[1] = 1'b1;
    tick();                      // SNOOP
    tick();                      // C2C word 0
    ramstate = R_ACCESS;
    tick();                      // C2C word 1
    ramstate = R_BUSY;
    #1;
    chk("c2c_word1_addr", AW'(ramaddr), AW'(32'h204));
    nRST = 1'b0;
    #1;
    check_idle("reset_mid_c2c");
    tick();
    check_idle("reset_held");
    clear_all();
    ramstate = R_FREE;
    for (int c = 0; c < CPUS; c++) set_req(c, T_RD, 32'h1000 + 32'(c*16));
    nRST = 1'b1;

    // Continuous BusRd from all caches: grant order 0,1,2,3,0
    run_txn(0, P_MEM, -1, '0, 0);
    run_txn(1, P_MEM, -1, '0, 0);
    run_txn(2, P_MEM, -1, '0, 0);
    run_txn(3, P_MEM, -1, '0, 0);
    run_txn(0, P_MEM, -1, '0, 0);
    clear_all();

    // Requestor withdraws mid-block: pointer stays at 1, counter restarts
    set_req(1, T_RD, 32'h700);
    tick();                      // SNOOP
    tick();                      // MEMRD word 0
    ramstate = R_ACCESS;
    tick();                      // MEMRD word 1
    clear_req(1);
    ramstate = R_BUSY;
    tick();
    @(negedge CLK);
    check_idle("abort");
    tick();
    set_req(1, T_RD, 32'h740);
    set_req(2, T_RD, 32'h780);
    run_txn(1, P_MEM, -1, '0, 0);
    clear_req(1);
    run_txn(2, P_MEM, -1, '0, 0);
    clear_all();

    // Randomized phase against the transaction-level model
    nRST = 1'b0; tick(); nRST = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < CPUS; c++) begin pend[c] = 1'b0; typ[c] = T_RD; end
    for (int it = 0; it < 60; it++) begin
      any = 1'b0;
      for (int c = 0; c < CPUS; c++) begin
        if (!pend[c] && $urandom_range(0, 1) == 1) begin
          t = $urandom_range(0, 3);
          set_req(c, t, $urandom & 32'hFFFF_FFFC);
          if (t == T_UPGR) ccwrite[c] = 1'($urandom_range(0, 1));
          pend[c] = 1'b1; typ[c] = t;
        end else if (!pend[c]) begin
          ccwrite[c] = 1'($urandom_range(0, 1));
        end
        any |= pend[c];
      end
      if (!any) begin
        t = $urandom_range(0, 3);
        r = $urandom_range(0, CPUS-1);
        set_req(r, t, $urandom & 32'hFFFF_FFFC);
        pend[r] = 1'b1; typ[r] = t;
      end
      r   = model_grant();
      own = model_owner(r);
      inv = '0;
      if (typ[r] == T_WB)        path = P_WB;
      else if (typ[r] == T_UPGR) path = P_ACK;
      else if (own >= 0)         path = P_C2C;
      else                       path = P_MEM;
      if (typ[r] == T_RDX || typ[r] == T_UPGR) begin
        inv = '1; inv[r] = 1'b0;
      end
      run_txn(r, path, own, inv, 1);
      pend[r] = 1'b0;
      clear_req(r);
      ccwrite[r] = 1'($urandom_range(0, 1));
      m_ptr = (r + 1) % CPUS;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
